// File: rtl/instr_packer_if.sv
// instr_packer_if
//   Bundles the request handshake, the instruction-memory write port and the
//   status outputs of instr_packer.
//   master : the side issuing requests and observing memory writes (loader/bench)
//   slave  : the packer itself
//   Signals:
//     clear                       sync clear of address counter, err_count, overflow
//     in_valid / in_ready         request handshake
//     ImmSel, opcode, rd, rs1,
//     rs2, funct3, funct7, imm    decoded instruction fields
//     mem_we, mem_addr, mem_wdata instruction-memory write port
//     err, err_count, overflow    reject pulse, saturating reject count, wrap flag
interface instr_packer_if #(
  parameter int INSTR_WIDTH = 32,
  parameter int ADDR_WIDTH  = 8
);
  logic                   clear;
  logic                   in_valid;
  logic                   in_ready;
  logic [2:0]             ImmSel;
  logic [6:0]             opcode;
  logic [4:0]             rd;
  logic [4:0]             rs1;
  logic [4:0]             rs2;
  logic [2:0]             funct3;
  logic [6:0]             funct7;
  logic [INSTR_WIDTH-1:0] imm;
  logic                   mem_we;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [INSTR_WIDTH-1:0] mem_wdata;
  logic                   err;
  logic [7:0]             err_count;
  logic                   overflow;

  modport master (
    output clear, in_valid, ImmSel, opcode, rd, rs1, rs2, funct3, funct7, imm,
    input  in_ready, mem_we, mem_addr, mem_wdata, err, err_count, overflow
  );

  modport slave (
    input  clear, in_valid, ImmSel, opcode, rd, rs1, rs2, funct3, funct7, imm,
    output in_ready, mem_we, mem_addr, mem_wdata, err, err_count, overflow
  );
endinterface

// File: rtl/instr_packer.sv
// instr_packer
//   Packs decoded RV32 instruction fields plus a full-width immediate into a
//   32-bit instruction word, rejects immediates that the chosen format cannot
//   represent, and writes accepted words to instruction memory at an
//   auto-incrementing word address.
//   Ports:
//     clk    clock
//     rst_n  asynchronous active-low reset
//     bus    instr_packer_if.slave (request fields, handshake, memory write
//            port, err pulse, err_count, overflow)
//   Flow: IDLE (accept) -> ENC (pack + legality) -> WR (write or reject).
module instr_packer #(
  parameter int INSTR_WIDTH = 32,
  parameter int ADDR_WIDTH  = 8
) (
  input logic           clk,
  input logic           rst_n,
  instr_packer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    WR   = 2'd2
  } state_t;

  state_t                 state;
  logic [2:0]             sel_q;
  logic [6:0]             opcode_q;
  logic [4:0]             rd_q;
  logic [4:0]             rs1_q;
  logic [4:0]             rs2_q;
  logic [2:0]             funct3_q;
  logic [6:0]             funct7_q;
  logic [INSTR_WIDTH-1:0] imm_q;
  logic                   we_q;
  logic                   err_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [INSTR_WIDTH-1:0] wdata_q;
  logic [7:0]             err_cnt_q;
  logic                   ovf_q;

  logic [INSTR_WIDTH-1:0] packed_word;
  logic                   legal;

  // Format-specific bit scatter and representability check on the captured
  // fields. "All equal" over an upper slice means the value is the sign
  // extension of the bits the format actually stores.
  always_comb begin
    packed_word = '0;
    legal       = 1'b0;
    case (sel_q)
      3'b000: begin
        packed_word = {imm_q[11:0], rs1_q, funct3_q, rd_q, opcode_q};
        legal       = (&imm_q[31:11]) | ~(|imm_q[31:11]);
      end
      3'b001: begin
        packed_word = {imm_q[11:5], rs2_q, rs1_q, funct3_q, imm_q[4:0], opcode_q};
        legal       = (&imm_q[31:11]) | ~(|imm_q[31:11]);
      end
      3'b010: begin
        packed_word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, funct3_q,
                       imm_q[4:1], imm_q[11], opcode_q};
        legal       = ~imm_q[0] & ((&imm_q[31:12]) | ~(|imm_q[31:12]));
      end
      3'b011: begin
        packed_word = {imm_q[31:12], rd_q, opcode_q};
        legal       = ~(|imm_q[11:0]);
      end
      3'b100: begin
        packed_word = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, opcode_q};
        legal       = ~imm_q[0] & ((&imm_q[31:20]) | ~(|imm_q[31:20]));
      end
      3'b101: begin
        packed_word = {funct7_q, rs2_q, rs1_q, funct3_q, rd_q, opcode_q};
        legal       = 1'b1;
      end
      default: begin
        packed_word = '0;
        legal       = 1'b0;
      end
    endcase
  end

  // Request FSM. mem_we/err are set on the ENC->WR edge so they are high for
  // exactly the WR cycle; in WR, mem_we itself tells whether the request was
  // legal, so the address or the reject count is updated on the WR->IDLE edge.
  // mem_wdata only changes for legal requests so it holds the last written word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel_q     <= '0;
      opcode_q  <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      funct3_q  <= '0;
      funct7_q  <= '0;
      imm_q     <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          we_q  <= 1'b0;
          err_q <= 1'b0;
          if (bus.clear) begin
            addr_q    <= '0;
            err_cnt_q <= '0;
            ovf_q     <= 1'b0;
          end else if (bus.in_valid) begin
            sel_q    <= bus.ImmSel;
            opcode_q <= bus.opcode;
            rd_q     <= bus.rd;
            rs1_q    <= bus.rs1;
            rs2_q    <= bus.rs2;
            funct3_q <= bus.funct3;
            funct7_q <= bus.funct7;
            imm_q    <= bus.imm;
            state    <= ENC;
          end
        end
        ENC: begin
          we_q  <= legal;
          err_q <= ~legal;
          if (legal) begin
            wdata_q <= packed_word;
          end
          state <= WR;
        end
        WR: begin
          we_q  <= 1'b0;
          err_q <= 1'b0;
          if (we_q) begin
            addr_q <= addr_q + 1'b1;
            if (&addr_q) begin
              ovf_q <= 1'b1;
            end
          end else if (err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'd1;
          end
          state <= IDLE;
        end
        default: begin
          we_q  <= 1'b0;
          err_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Ready is gated by rst_n so the block never advertises ready while held in reset.
  assign bus.in_ready  = (state == IDLE) && !bus.clear && rst_n;
  assign bus.mem_we    = we_q;
  assign bus.err       = err_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.err_count = err_cnt_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_instr_packer.sv
// tb_instr_packer
//   Drives directed and random requests into instr_packer (ADDR_WIDTH=2 so the
//   address wrap is reached quickly) and checks every cycle against a
//   behavioural model: legality by numeric range, expected address/err_count/
//   overflow as plain counters, and each written word decoded back into its
//   fields and immediate. Literal words and counter values pin the model.
module tb_instr_packer;

  localparam int AW = 2;

  typedef struct packed {
    logic [2:0]  sel;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        lit_valid;
    logic [31:0] lit;
  } req_t;

  logic clk;
  logic rst_n;

  instr_packer_if #(.INSTR_WIDTH(32), .ADDR_WIDTH(AW)) bus ();

  instr_packer #(.INSTR_WIDTH(32), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  // Literal expectation attached to the request currently being driven.
  logic        drv_lit_valid = 1'b0;
  logic [31:0] drv_lit       = '0;

  // Model state: stage 0 idle, 1 encoding, 2 writing.
  int   m_stage = 0;
  int   m_addr  = 0;
  int   m_cnt   = 0;
  bit   m_ovf   = 1'b0;
  req_t m_req   = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Representability judged numerically on the signed immediate.
  function automatic bit isLegal(input logic [2:0] sel, input logic [31:0] im);
    longint v;
    v = longint'($signed(im));
    case (sel)
      3'd0, 3'd1: return (v >= -2048) && (v <= 2047);
      3'd2:       return (im[0] == 1'b0) && (v >= -4096) && (v <= 4095);
      3'd3:       return (im[11:0] == 12'h000);
      3'd4:       return (im[0] == 1'b0) && (v >= -(longint'(1) << 20)) && (v <= (longint'(1) << 20) - 1);
      3'd5:       return 1'b1;
      default:    return 1'b0;
    endcase
  endfunction

  // Golden immediate extraction (as a core decoder would) plus field recovery.
  function automatic bit decodeMatches(input logic [31:0] w, input req_t r);
    logic [31:0] rec;
    bit ok;
    ok = (w[6:0] == r.op);
    case (r.sel)
      3'd0: begin
        rec = {{20{w[31]}}, w[31:20]};
        ok = ok && rec == r.imm && w[11:7] == r.rd && w[19:15] == r.rs1 && w[14:12] == r.f3;
      end
      3'd1: begin
        rec = {{20{w[31]}}, w[31:25], w[11:7]};
        ok = ok && rec == r.imm && w[24:20] == r.rs2 && w[19:15] == r.rs1 && w[14:12] == r.f3;
      end
      3'd2: begin
        rec = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        ok = ok && rec == r.imm && w[24:20] == r.rs2 && w[19:15] == r.rs1 && w[14:12] == r.f3;
      end
      3'd3: begin
        rec = {w[31:12], 12'h000};
        ok = ok && rec == {r.imm[31:12], 12'h000} && w[11:7] == r.rd;
      end
      3'd4: begin
        rec = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        ok = ok && rec == r.imm && w[11:7] == r.rd;
      end
      3'd5: begin
        ok = ok && w[31:25] == r.f7 && w[24:20] == r.rs2 && w[19:15] == r.rs1 &&
             w[14:12] == r.f3 && w[11:7] == r.rd;
      end
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Behavioural model of the request lifecycle and the three counters.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_stage <= 0;
      m_addr  <= 0;
      m_cnt   <= 0;
      m_ovf   <= 1'b0;
    end else begin
      case (m_stage)
        0: begin
          if (bus.clear) begin
            m_addr <= 0;
            m_cnt  <= 0;
            m_ovf  <= 1'b0;
          end else if (bus.in_valid) begin
            m_req   <= '{bus.ImmSel, bus.opcode, bus.rd, bus.rs1, bus.rs2, bus.funct3,
                         bus.funct7, bus.imm, drv_lit_valid, drv_lit};
            m_stage <= 1;
          end
        end
        1: m_stage <= 2;
        default: begin
          if (isLegal(m_req.sel, m_req.imm)) begin
            m_addr <= (m_addr + 1) % (1 << AW);
            if (m_addr == (1 << AW) - 1) m_ovf <= 1'b1;
          end else if (m_cnt < 255) begin
            m_cnt <= m_cnt + 1;
          end
          m_stage <= 0;
        end
      endcase
    end
  end

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    bit exp_we;
    bit exp_err;
    bit exp_ready;
    exp_we    = rst_n && (m_stage == 2) && isLegal(m_req.sel, m_req.imm);
    exp_err   = rst_n && (m_stage == 2) && !isLegal(m_req.sel, m_req.imm);
    exp_ready = rst_n && (m_stage == 0) && !bus.clear;
    checkOutput("in_ready", {31'b0, bus.in_ready}, {31'b0, exp_ready});
    checkOutput("mem_we", {31'b0, bus.mem_we}, {31'b0, exp_we});
    checkOutput("err", {31'b0, bus.err}, {31'b0, exp_err});
    checkOutput("mem_addr", {{(32-AW){1'b0}}, bus.mem_addr}, 32'(m_addr));
    checkOutput("err_count", {24'b0, bus.err_count}, 32'(m_cnt));
    checkOutput("overflow", {31'b0, bus.overflow}, {31'b0, m_ovf});
    if (exp_we) begin
      checkOutput("decode", {31'b0, decodeMatches(bus.mem_wdata, m_req)}, 32'd1);
      if (m_req.lit_valid) checkOutput("wdata", bus.mem_wdata, m_req.lit);
    end
  end

  task automatic junkFields();
    bus.ImmSel = 3'($urandom);
    bus.opcode = 7'($urandom);
    bus.rd     = 5'($urandom);
    bus.rs1    = 5'($urandom);
    bus.rs2    = 5'($urandom);
    bus.funct3 = 3'($urandom);
    bus.funct7 = 7'($urandom);
    bus.imm    = $urandom;
  endtask

  // Called just after an active edge; returns just after the accepting edge.
  task automatic applyStimulus(input logic [2:0] sel, input logic [6:0] op,
                               input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                               input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im,
                               input bit lv, input logic [31:0] lw, input int gap);
    int waited;
    waited = 0;
    bus.in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #2; end
    while (m_stage != 0 && waited < 10) begin
      bus.in_valid = 1'($urandom);
      junkFields();
      @(posedge clk); #2;
      waited++;
    end
    if (waited >= 10) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL idle_wait: model never returned to idle, got stage %0d required 0", m_stage);
    end
    bus.ImmSel = sel; bus.opcode = op; bus.rd = d; bus.rs1 = s1; bus.rs2 = s2;
    bus.funct3 = f3; bus.funct7 = f7; bus.imm = im;
    drv_lit_valid = lv; drv_lit = lw;
    bus.in_valid = 1'b1;
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
    drv_lit_valid = 1'b0;
    junkFields();
  endtask

  task automatic drain();
    repeat (3) begin @(posedge clk); #2; end
  endtask

  task automatic sendRandom(input bit jitter);
    logic [2:0]  sel;
    logic [31:0] r;
    logic [31:0] im;
    sel = 3'($urandom_range(0, 5));
    r   = $urandom;
    case (sel)
      3'd0, 3'd1: im = {{20{r[11]}}, r[11:0]};
      3'd2:       im = {{19{r[12]}}, r[12:1], 1'b0};
      3'd3:       im = {r[31:12], 12'h000};
      3'd4:       im = {{11{r[20]}}, r[20:1], 1'b0};
      default:    im = r;
    endcase
    applyStimulus(sel, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                  3'($urandom), 7'($urandom), im, 1'b0, 32'h0,
                  jitter ? $urandom_range(0, 3) : 0);
  endtask

  initial begin
    rst_n = 1'b1;
    bus.clear = 1'b0;
    bus.in_valid = 1'b0;
    junkFields();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    checkOutput("reset_addr", {{(32-AW){1'b0}}, bus.mem_addr}, 32'd0);
    checkOutput("reset_wdata", bus.mem_wdata, 32'h0);

    // addi x1,x0,-1 ; beq x1,x2,+8 ; beq with odd offset (rejected)
    applyStimulus(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 1'b1, 32'hFFF00093, 0);
    applyStimulus(3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, 1'b1, 32'h00208463, 0);
    applyStimulus(3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7, 1'b0, 32'h0, 0);
    drain();
    checkOutput("beq7_err_count", {24'b0, bus.err_count}, 32'd1);
    checkOutput("beq7_addr", {{(32-AW){1'b0}}, bus.mem_addr}, 32'd2);

    // lui x5 ; jal x1,-4 (4th write wraps) ; lui with low bits (rejected)
    applyStimulus(3'd3, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b1, 32'h123452B7, 0);
    drain();
    checkOutput("pre_wrap_overflow", {31'b0, bus.overflow}, 32'd0);
    applyStimulus(3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 1'b1, 32'hFFDFF0EF, 0);
    drain();
    checkOutput("wrap_overflow", {31'b0, bus.overflow}, 32'd1);
    checkOutput("wrap_addr", {{(32-AW){1'b0}}, bus.mem_addr}, 32'd0);
    applyStimulus(3'd3, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001, 1'b0, 32'h0, 0);

    // sw x3,-12(x2) ; add x3,x1,x2 ; illegal ImmSel
    applyStimulus(3'd1, 7'h23, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, 32'hFFFFFFF4, 1'b1, 32'hFE312A23, 0);
    applyStimulus(3'd5, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEADBEEF, 1'b1, 32'h002081B3, 0);
    applyStimulus(3'd6, 7'h13, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'h0, 1'b0, 32'h0, 0);
    drain();
    checkOutput("seq_addr", {{(32-AW){1'b0}}, bus.mem_addr}, 32'd2);
    checkOutput("seq_overflow", {31'b0, bus.overflow}, 32'd1);
    checkOutput("seq_err_count", {24'b0, bus.err_count}, 32'd3);

    // Reset while the request is in ENC: everything drops immediately.
    applyStimulus(3'd0, 7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 32'h0, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
    checkOutput("rst_err", {31'b0, bus.err}, 32'd0);
    checkOutput("rst_addr", {{(32-AW){1'b0}}, bus.mem_addr}, 32'd0);
    checkOutput("rst_err_count", {24'b0, bus.err_count}, 32'd0);
    checkOutput("rst_overflow", {31'b0, bus.overflow}, 32'd0);
    checkOutput("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    checkOutput("rst_wdata", bus.mem_wdata, 32'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    drain();
    checkOutput("post_rst_addr", {{(32-AW){1'b0}}, bus.mem_addr}, 32'd0);

    // Build up state, then clear together with a valid request.
    repeat (4) sendRandom(1'b0);
    applyStimulus(3'd7, 7'h13, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'h0, 1'b0, 32'h0, 0);
    drain();
    checkOutput("pre_clear_overflow", {31'b0, bus.overflow}, 32'd1);
    checkOutput("pre_clear_err_count", {24'b0, bus.err_count}, 32'd1);
    bus.clear = 1'b1;
    bus.in_valid = 1'b1;
    bus.ImmSel = 3'd0;
    bus.imm = 32'd1;
    @(posedge clk); #2;
    bus.clear = 1'b0;
    bus.in_valid = 1'b0;
    drain();
    checkOutput("clear_addr", {{(32-AW){1'b0}}, bus.mem_addr}, 32'd0);
    checkOutput("clear_overflow", {31'b0, bus.overflow}, 32'd0);
    checkOutput("clear_err_count", {24'b0, bus.err_count}, 32'd0);

    // Random legal traffic with valid jitter.
    repeat (40) sendRandom(1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
